// File: rtl/psum_drain_collector.sv
// Deskews the diagonal partial-sum stream from the PE array bottom edge into aligned rows.
// Rows are buffered in a small FIFO, quantised and serialised lane by lane to the ofmap writer.
module psum_drain_collector #(
    parameter int NUM_LANES   = 16,
    parameter int ACCUM_WIDTH = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [7:0]                       ofmap_size,
    input  logic [4:0]                       shift_amt,
    input  logic                             relu_en,
    input  logic [NUM_LANES*ACCUM_WIDTH-1:0] lane_psum_in,
    input  logic [NUM_LANES-1:0]             lane_valid_in,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow_err,
    output logic                             skew_err
);

    localparam int ROW_W  = NUM_LANES * ACCUM_WIDTH;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int AW1    = ACCUM_WIDTH + 1;
    localparam logic [LANE_W-1:0]             LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0]              FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic signed [ACCUM_WIDTH:0]   SAT_MAX   = AW1'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACCUM_WIDTH:0]   SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    start_fire;
    logic [7:0]              size_q, size_d, rows_in_q, rows_in_d;
    logic [4:0]              shift_q, shift_d;
    logic                    relu_q, relu_d;
    logic [LANE_W-1:0]       lane_idx_q, lane_idx_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    last_pushed_q, last_pushed_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                    overflow_q, overflow_d, skew_q, skew_d;

    logic [ROW_W-1:0]        row_flat;
    logic [NUM_LANES-1:0]    row_vld;
    logic [ROW_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [ROW_W-1:0]        src_row;
    logic [ACCUM_WIDTH-1:0]  src_word;
    logic                    row_ok, can_load, load_en, pop, push, fifo_full, final_push, drain_complete;

    // Lane i gets NUM_LANES-i register stages so that all lanes of a row line up.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int STAGES = NUM_LANES - i;
        logic [ACCUM_WIDTH-1:0] data_q [STAGES];
        logic [STAGES-1:0]      vld_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
                for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
            end else begin
                vld_q[0]  <= lane_valid_in[i];
                data_q[0] <= lane_psum_in[i*ACCUM_WIDTH +: ACCUM_WIDTH];
                for (int s = 1; s < STAGES; s++) begin
                    vld_q[s]  <= vld_q[s-1];
                    data_q[s] <= data_q[s-1];
                end
            end
        end

        assign row_flat[i*ACCUM_WIDTH +: ACCUM_WIDTH] = data_q[STAGES-1];
        assign row_vld[i]                             = vld_q[STAGES-1];
    end

    function automatic logic [DATA_WIDTH-1:0] quantise(input logic [ACCUM_WIDTH-1:0] x,
                                                       input logic [4:0] sh, input logic relu);
        logic signed [ACCUM_WIDTH:0] y;
        logic signed [ACCUM_WIDTH:0] rnd;
        y = $signed({x[ACCUM_WIDTH-1], x});
        if (sh != 5'd0) begin
            rnd = AW1'(1) << (sh - 5'd1);
            y   = (y + rnd) >>> sh;
        end
        if (relu && y[ACCUM_WIDTH]) y = '0;
        if (y > SAT_MAX)      y = SAT_MAX;
        else if (y < SAT_MIN) y = SAT_MIN;
        return y[DATA_WIDTH-1:0];
    endfunction

    // An empty FIFO lets the arriving row feed the output register directly.
    assign row_ok     = (state_q == S_COLLECT) && row_vld[0] && (rows_in_q < size_q);
    assign can_load   = !out_valid_q || out_ready;
    assign load_en    = can_load && ((count_q != '0) || row_ok);
    assign pop        = load_en && (lane_idx_q == LAST_LANE);
    assign fifo_full  = (count_q == FULL_CNT);
    assign push       = row_ok && (!fifo_full || pop);
    assign final_push = push && (rows_in_q + 8'd1 == size_q);
    assign src_row    = (count_q != '0) ? fifo_mem[rd_ptr_q] : row_flat;
    assign src_word   = src_row[lane_idx_q*ACCUM_WIDTH +: ACCUM_WIDTH];
    assign drain_complete = (rows_in_q == size_q) && (count_q == '0) && (!out_valid_q || out_ready);

    always_comb begin
        state_d    = state_q;
        start_fire = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                start_fire = 1'b1;
                state_d    = (ofmap_size == 8'd0) ? S_DONE : S_COLLECT;
            end
            S_COLLECT: if (drain_complete) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: every _d takes its _q value first, so no path through this block infers a latch.
    always_comb begin
        size_d        = size_q;
        shift_d       = shift_q;
        relu_d        = relu_q;
        rows_in_d     = rows_in_q;
        lane_idx_d    = lane_idx_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        last_pushed_d = last_pushed_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        overflow_d    = overflow_q;
        skew_d        = skew_q;

        if (can_load) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (load_en) begin
            out_data_d  = quantise(src_word, shift_q, relu_q);
            out_valid_d = 1'b1;
            out_last_d  = (lane_idx_q == LAST_LANE) &&
                          (((count_q == CNT_W'(1)) && last_pushed_q) || ((count_q == '0) && final_push));
            lane_idx_d  = pop ? '0 : lane_idx_q + LANE_W'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (row_ok) begin
            rows_in_d = rows_in_q + 8'd1;
            if (row_vld != {NUM_LANES{1'b1}}) skew_d = 1'b1;
            if (!push) overflow_d = 1'b1;
        end
        if (final_push) last_pushed_d = 1'b1;

        if (start_fire) begin
            size_d        = ofmap_size;
            shift_d       = shift_amt;
            relu_d        = relu_en;
            rows_in_d     = '0;
            lane_idx_d    = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            last_pushed_d = 1'b0;
            overflow_d    = 1'b0;
            skew_d        = 1'b0;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_q        <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            rows_in_q     <= '0;
            lane_idx_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_pushed_q <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            overflow_q    <= 1'b0;
            skew_q        <= 1'b0;
        end else begin
            size_q        <= size_d;
            shift_q       <= shift_d;
            relu_q        <= relu_d;
            rows_in_q     <= rows_in_d;
            lane_idx_q    <= lane_idx_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_pushed_q <= last_pushed_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            overflow_q    <= overflow_d;
            skew_q        <= skew_d;
        end
    end

    // NOTE: row storage has no reset; the pointers and count alone define what it holds.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= row_flat;
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign busy         = (state_q == S_COLLECT);
    assign done         = (state_q == S_DONE);
    assign overflow_err = overflow_q;
    assign skew_err     = skew_q;

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed bench for psum_drain_collector with 4 lanes: quantisation table plus
// hand-built sequences for timing, back-pressure, stalls, skew faults and reset.
module tb_psum_drain_collector;

    localparam int NL   = 4;
    localparam int AW   = 32;
    localparam int DW   = 16;
    localparam int FD   = 4;
    localparam int MAXC = 256;
    localparam int MAXW = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        ofmap_size;
    logic [4:0]        shift_amt;
    logic              relu_en;
    logic [NL*AW-1:0]  lane_psum_in;
    logic [NL-1:0]     lane_valid_in;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              overflow_err;
    logic              skew_err;

    always #5 clk = ~clk;

    psum_drain_collector #(
        .NUM_LANES(NL), .ACCUM_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ofmap_size(ofmap_size),
        .shift_amt(shift_amt), .relu_en(relu_en), .lane_psum_in(lane_psum_in),
        .lane_valid_in(lane_valid_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .overflow_err(overflow_err), .skew_err(skew_err)
    );

    typedef struct {
        logic [4:0]           shift;
        logic                 relu;
        logic [NL-1:0][AW-1:0] w;
        logic [NL-1:0][DW-1:0] exp;
    } qvec_t;

    qvec_t qv [6];

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] sdat [MAXC][NL];
    logic [NL-1:0] svld [MAXC];

    logic [DW-1:0] cap_data [MAXW];
    logic          cap_last [MAXW];
    int            cap_cyc  [MAXW];
    int            cap_n, done_count, done_cyc, valid_seen;
    logic          prev_hold;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_q(input int idx, input logic [4:0] sh, input logic relu,
                         input logic [AW-1:0] w0, input logic [AW-1:0] w1,
                         input logic [AW-1:0] w2, input logic [AW-1:0] w3,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3);
        qv[idx].shift  = sh;
        qv[idx].relu   = relu;
        qv[idx].w[0]   = w0;  qv[idx].w[1]   = w1;  qv[idx].w[2]   = w2;  qv[idx].w[3]   = w3;
        qv[idx].exp[0] = e0;  qv[idx].exp[1] = e1;  qv[idx].exp[2] = e2;  qv[idx].exp[3] = e3;
    endtask

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            svld[c] = '0;
            for (int l = 0; l < NL; l++) sdat[c][l] = '0;
        end
    endtask

    // Row whose lane 0 appears at cycle t0; lane i appears i cycles later.
    task automatic add_row(input int t0, input logic [AW-1:0] w0, input logic [AW-1:0] w1,
                           input logic [AW-1:0] w2, input logic [AW-1:0] w3, input logic [NL-1:0] vmask);
        logic [AW-1:0] w [NL];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < NL; i++) begin
            sdat[t0+i][i] = w[i];
            svld[t0+i][i] = vmask[i];
        end
    endtask

    task automatic do_start(input logic [7:0] size, input logic [4:0] sh, input logic relu);
        @(negedge clk);
        start         = 1'b1;
        ofmap_size    = size;
        shift_amt     = sh;
        relu_en       = relu;
        lane_valid_in = '0;
        cap_n         = 0;
        done_count    = 0;
        done_cyc      = -1;
        valid_seen    = 0;
    endtask

    // mode 0: out_ready low, 1: out_ready high, 2: random out_ready.
    task automatic run_cycles(input int k0, input int n, input int mode);
        for (int k = k0; k < k0 + n; k++) begin
            @(negedge clk);
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            start         = 1'b0;
            lane_valid_in = svld[k];
            for (int l = 0; l < NL; l++) lane_psum_in[l*AW +: AW] = sdat[k][l];
            case (mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) valid_seen++;
            if (out_valid && out_ready) begin
                if (cap_n < MAXW) begin
                    cap_data[cap_n] = out_data;
                    cap_last[cap_n] = out_last;
                    cap_cyc[cap_n]  = k;
                end
                cap_n++;
            end
            if (done) begin
                done_count++;
                done_cyc = k;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    endtask

    function automatic int count_lasts(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n && i < MAXW; i++) if (cap_last[i]) c++;
        return c;
    endfunction

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        ofmap_size    = '0;
        shift_amt     = '0;
        relu_en       = 1'b0;
        lane_psum_in  = '0;
        lane_valid_in = '0;
        out_ready     = 1'b0;
        prev_hold     = 1'b0;
        prev_data     = '0;
        cap_n = 0; done_count = 0; done_cyc = -1; valid_seen = 0;

        set_q(0, 5'd4,  1'b0, 32'd24, -32'sd24, 32'h7FFF_FFFF, 32'h8000_0000, 16'h0002, 16'hFFFF, 16'h7FFF, 16'h8000);
        set_q(1, 5'd4,  1'b1, 32'd24, -32'sd24, 32'h7FFF_FFFF, 32'h8000_0000, 16'h0002, 16'h0000, 16'h7FFF, 16'h0000);
        set_q(2, 5'd0,  1'b0, 32'd100, -32'sd100, 32'd32768, -32'sd32769,     16'h0064, 16'hFF9C, 16'h7FFF, 16'h8000);
        set_q(3, 5'd1,  1'b0, 32'd3, -32'sd3, 32'd1, -32'sd1,                 16'h0002, 16'hFFFF, 16'h0001, 16'h0000);
        set_q(4, 5'd8,  1'b1, 32'd25728, 32'd127, -32'sd129, 32'h0080_0000,   16'h0065, 16'h0000, 16'h0000, 16'h7FFF);
        set_q(5, 5'd31, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'hC000_0000, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000);

        clear_stim();
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow_err, 0);
        check("rst_skew", skew_err, 0);
        reset = 1'b0;

        // Basic drain; a third row beyond ofmap_size must be ignored.
        clear_stim();
        add_row(0, 32'd1, 32'd2, 32'd3, 32'd4, 4'hF);
        add_row(1, 32'd5, 32'd6, 32'd7, 32'd8, 4'hF);
        add_row(2, 32'd9, 32'd9, 32'd9, 32'd9, 4'hF);
        do_start(8'd2, 5'd0, 1'b0);
        run_cycles(0, 1, 1);
        check("basic_busy", busy, 1);
        run_cycles(1, 19, 1);
        check("basic_count", cap_n, 8);
        for (int i = 0; i < 8; i++) check($sformatf("basic_word%0d", i), cap_data[i], 16'(i + 1));
        check("basic_first_cyc", cap_cyc[0], 5);
        check("basic_last_cyc", cap_cyc[7], 12);
        check("basic_last_flag", cap_last[7], 1);
        check("basic_num_last", count_lasts(8), 1);
        check("basic_done_count", done_count, 1);
        check("basic_done_cyc", done_cyc, 13);
        check("basic_overflow", overflow_err, 0);
        check("basic_busy_end", busy, 0);

        // Quantisation table.
        for (int e = 0; e < 6; e++) begin
            clear_stim();
            add_row(0, qv[e].w[0], qv[e].w[1], qv[e].w[2], qv[e].w[3], 4'hF);
            do_start(8'd1, qv[e].shift, qv[e].relu);
            run_cycles(0, 14, 1);
            check($sformatf("q%0d_count", e), cap_n, 4);
            for (int l = 0; l < NL; l++)
                check($sformatf("q%0d_lane%0d", e, l), cap_data[l], qv[e].exp[l]);
            check($sformatf("q%0d_last", e), cap_last[3], 1);
            check($sformatf("q%0d_done", e), done_count, 1);
        end

        // Back-pressure: four rows fill the FIFO, the fifth is dropped.
        clear_stim();
        for (int r = 0; r < 5; r++)
            add_row(r, 32'(100*(r+1)), 32'(100*(r+1)+1), 32'(100*(r+1)+2), 32'(100*(r+1)+3), 4'hF);
        do_start(8'd5, 5'd0, 1'b0);
        run_cycles(0, 20, 0);
        check("bp_overflow", overflow_err, 1);
        check("bp_held_count", cap_n, 0);
        check("bp_no_done", done_count, 0);
        check("bp_busy", busy, 1);
        clear_stim();
        run_cycles(0, 30, 1);
        check("bp_count", cap_n, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("bp_word%0d", i), cap_data[i], 16'(100*(i/4 + 1) + i%4));
        check("bp_num_last", count_lasts(16), 0);
        check("bp_done", done_count, 1);
        check("bp_overflow_sticky", overflow_err, 1);

        // Random stalls: order preserved, data held while stalled.
        clear_stim();
        add_row(0, 32'd1000, 32'd1001, 32'd1002, 32'd1003, 4'hF);
        add_row(3, 32'd2000, 32'd2001, 32'd2002, 32'd2003, 4'hF);
        add_row(6, 32'd3000, 32'd3001, 32'd3002, 32'd3003, 4'hF);
        do_start(8'd3, 5'd0, 1'b0);
        run_cycles(0, 200, 2);
        check("stall_count", cap_n, 12);
        for (int i = 0; i < 12; i++)
            check($sformatf("stall_word%0d", i), cap_data[i], 16'(1000*(i/4 + 1) + i%4));
        check("stall_last", cap_last[11], 1);
        check("stall_num_last", count_lasts(12), 1);
        check("stall_done", done_count, 1);
        check("stall_overflow", overflow_err, 0);

        // Skew fault on lane 2 of the first row.
        clear_stim();
        add_row(0, 32'd11, 32'd12, 32'd13, 32'd14, 4'b1011);
        add_row(1, 32'd21, 32'd22, 32'd23, 32'd24, 4'hF);
        do_start(8'd2, 5'd0, 1'b0);
        run_cycles(0, 20, 1);
        check("skew_err", skew_err, 1);
        check("skew_count", cap_n, 8);
        check("skew_row0_lane0", cap_data[0], 16'd11);
        check("skew_row0_lane3", cap_data[3], 16'd14);
        check("skew_row1_lane3", cap_data[7], 16'd24);
        check("skew_last", cap_last[7], 1);
        check("skew_done", done_count, 1);

        // Zero-size drain: done next cycle, nothing emitted, skew_err cleared.
        clear_stim();
        do_start(8'd0, 5'd0, 1'b0);
        run_cycles(0, 4, 1);
        check("zero_skew_cleared", skew_err, 0);
        check("zero_done_count", done_count, 1);
        check("zero_done_cyc", done_cyc, 0);
        check("zero_valid_seen", valid_seen, 0);

        // Reset in the middle of a stalled drain.
        clear_stim();
        add_row(0, 32'd5, 32'd6, 32'd7, 32'd8, 4'hF);
        add_row(1, 32'd9, 32'd10, 32'd11, 32'd12, 4'hF);
        do_start(8'd2, 5'd0, 1'b0);
        run_cycles(0, 8, 0);
        check("mid_valid_before", out_valid, 1);
        @(negedge clk);
        lane_valid_in = '0;
        out_ready     = 1'b0;
        reset         = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        reset     = 1'b0;
        prev_hold = 1'b0;
        clear_stim();
        add_row(0, 32'd7, -32'sd7, 32'd300, 32'd40000, 4'hF);
        do_start(8'd1, 5'd0, 1'b0);
        run_cycles(0, 15, 1);
        check("post_rst_count", cap_n, 4);
        check("post_rst_w0", cap_data[0], 16'h0007);
        check("post_rst_w1", cap_data[1], 16'hFFF9);
        check("post_rst_w2", cap_data[2], 16'h012C);
        check("post_rst_w3", cap_data[3], 16'h7FFF);
        check("post_rst_last", cap_last[3], 1);
        check("post_rst_done", done_count, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
